// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback stage: load-entry payload,
// load size encoding, and the load alignment/extension functions.
package wb_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2,
    LD_D = 2'd3
  } ld_size_e;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
    logic [2:0]       offset;
    ld_size_e         size;
    logic             is_unsigned;
  } ld_entry_t;

  // Right-justify the addressed bytes and sign/zero-extend them to XLEN.
  function automatic logic [XLEN-1:0] load_extend(
    input logic [XLEN-1:0] data,
    input logic [2:0]      offset,
    input ld_size_e        size,
    input logic            is_unsigned
  );
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] result;
    shifted = data >> {offset, 3'b000};
    result  = shifted;
    case (size)
      LD_B: result = is_unsigned ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                 : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      LD_H: result = is_unsigned ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                 : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      LD_W: result = is_unsigned ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                                 : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      LD_D: result = shifted;
    endcase
    return result;
  endfunction

  // Natural alignment: the offset must be a multiple of the access size.
  function automatic logic load_misaligned(
    input logic [2:0] offset,
    input ld_size_e   size
  );
    logic bad;
    bad = 1'b0;
    case (size)
      LD_B: bad = 1'b0;
      LD_H: bad = offset[0];
      LD_W: bad = |offset[1:0];
      LD_D: bad = |offset;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Small circular FIFO holding raw load responses until the writeback port
// can retire them.
module wb_load_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  ld_entry_t                    din,
  input  logic                         pop,
  output ld_entry_t                    head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  ld_entry_t        mem_q [DEPTH];
  ld_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Pointer/count update; depth is a power of two so pointers wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count/pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: merges ALU results and queued, extended load data onto
// the single register-file write port, with loads taking strict priority.
module writeback_stage #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned LQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_result,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  input  logic [2:0]      ld_offset,
  input  logic [1:0]      ld_size,
  input  logic            ld_unsigned,
  output logic            write_sig,
  output logic [4:0]      write_reg,
  output logic [XLEN-1:0] write_val,
  output logic            misalign_err,
  output logic [63:0]     wb_count
);

  import wb_pkg::*;

  localparam int unsigned CNT_W = $clog2(LQ_DEPTH + 1);

  logic             lq_push, lq_pop, lq_full, lq_empty;
  logic [CNT_W-1:0] lq_count;
  ld_entry_t        lq_in, lq_head;
  logic             alu_fire;
  logic             head_misaligned;
  logic [XLEN-1:0]  head_value;

  logic             sel_valid;
  logic [4:0]       sel_rd;
  logic [XLEN-1:0]  sel_val;

  logic             write_sig_q, write_sig_d;
  logic [4:0]       write_reg_q, write_reg_d;
  logic [XLEN-1:0]  write_val_q, write_val_d;
  logic             misalign_err_q, misalign_err_d;
  logic [63:0]      wb_count_q, wb_count_d;

  // Handshake readiness depends only on registered queue occupancy.
  assign ld_ready  = !lq_full;
  assign alu_ready = (lq_count == '0);

  always_comb begin
    lq_in.rd          = ld_rd;
    lq_in.data        = ld_data;
    lq_in.offset      = ld_offset;
    lq_in.size        = ld_size_e'(ld_size);
    lq_in.is_unsigned = ld_unsigned;
    lq_push           = ld_valid && ld_ready;
    lq_pop            = !lq_empty;
    alu_fire          = alu_valid && alu_ready;
    head_misaligned   = load_misaligned(lq_head.offset, lq_head.size);
    head_value        = load_extend(lq_head.data, lq_head.offset,
                                    lq_head.size, lq_head.is_unsigned);
  end

  wb_load_fifo #(
    .DEPTH (LQ_DEPTH)
  ) u_load_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (lq_push),
    .din   (lq_in),
    .pop   (lq_pop),
    .head  (lq_head),
    .full  (lq_full),
    .empty (lq_empty),
    .count (lq_count)
  );

  // Source selection: queued loads first, then an ALU transfer, else idle.
  always_comb begin
    sel_valid      = 1'b0;
    sel_rd         = '0;
    sel_val        = '0;
    misalign_err_d = 1'b0;
    if (lq_pop) begin
      if (head_misaligned) begin
        misalign_err_d = 1'b1;
      end else begin
        sel_valid = 1'b1;
        sel_rd    = lq_head.rd;
        sel_val   = head_value;
      end
    end else if (alu_fire) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd;
      sel_val   = alu_result;
    end
  end

  // Retire: x0 targets count as retired but never raise the write enable.
  always_comb begin
    write_sig_d = 1'b0;
    write_reg_d = write_reg_q;
    write_val_d = write_val_q;
    wb_count_d  = wb_count_q;
    if (sel_valid) begin
      write_sig_d = (sel_rd != 5'd0);
      write_reg_d = sel_rd;
      write_val_d = sel_val;
      wb_count_d  = wb_count_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write_sig_q    <= 1'b0;
      write_reg_q    <= '0;
      write_val_q    <= '0;
      misalign_err_q <= 1'b0;
      wb_count_q     <= '0;
    end else begin
      write_sig_q    <= write_sig_d;
      write_reg_q    <= write_reg_d;
      write_val_q    <= write_val_d;
      misalign_err_q <= misalign_err_d;
      wb_count_q     <= wb_count_d;
    end
  end

  assign write_sig    = write_sig_q;
  assign write_reg    = write_reg_q;
  assign write_val    = write_val_q;
  assign misalign_err = misalign_err_q;
  assign wb_count     = wb_count_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: table of single-transaction vectors
// plus hand-written priority and mid-operation reset sequences.
module tb_writeback_stage;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [63:0] alu_result;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [63:0] ld_data;
  logic [2:0]  ld_offset;
  logic [1:0]  ld_size;
  logic        ld_unsigned;
  logic        write_sig;
  logic [4:0]  write_reg;
  logic [63:0] write_val;
  logic        misalign_err;
  logic [63:0] wb_count;

  int          n_tests;
  int          n_fail;
  int          cur_idx;
  logic [63:0] exp_cnt;

  writeback_stage #(
    .XLEN     (64),
    .LQ_DEPTH (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_rd       (alu_rd),
    .alu_result   (alu_result),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_rd        (ld_rd),
    .ld_data      (ld_data),
    .ld_offset    (ld_offset),
    .ld_size      (ld_size),
    .ld_unsigned  (ld_unsigned),
    .write_sig    (write_sig),
    .write_reg    (write_reg),
    .write_val    (write_val),
    .misalign_err (misalign_err),
    .wb_count     (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_ld;
    logic [4:0]  rd;
    logic [63:0] data;
    logic [2:0]  off;
    logic [1:0]  size;
    logic        uns;
    logic        exp_sig;
    logic        exp_err;
    logic [63:0] exp_val;
    logic        cnt_inc;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic is_ld, input logic [4:0] rd,
                              input logic [63:0] data, input logic [2:0] off,
                              input logic [1:0] size, input logic uns,
                              input logic exp_sig, input logic exp_err,
                              input logic [63:0] exp_val, input logic cnt_inc);
    vec_t v;
    v.is_ld = is_ld;  v.rd = rd;   v.data = data;   v.off = off;
    v.size = size;    v.uns = uns; v.exp_sig = exp_sig;
    v.exp_err = exp_err; v.exp_val = exp_val; v.cnt_inc = cnt_inc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [vec %0d]: got %h expected %h", name, cur_idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_result = '0;
    ld_valid = 1'b0;  ld_rd = '0;  ld_data = '0;
    ld_offset = '0;   ld_size = '0; ld_unsigned = 1'b0;
  endtask

  task automatic drive_ld(input logic [4:0] rd, input logic [63:0] data,
                          input logic [2:0] off, input logic [1:0] size, input logic uns);
    ld_valid = 1'b1; ld_rd = rd; ld_data = data;
    ld_offset = off; ld_size = size; ld_unsigned = uns;
  endtask

  task automatic run_vec(input vec_t v);
    if (v.is_ld) drive_ld(v.rd, v.data, v.off, v.size, v.uns);
    else begin
      alu_valid = 1'b1; alu_rd = v.rd; alu_result = v.data;
    end
    tick();
    idle_inputs();
    if (v.is_ld) begin
      chk("load_latency_sig", {63'd0, write_sig}, 64'd0);
      tick();
    end
    if (v.cnt_inc) exp_cnt = exp_cnt + 64'd1;
    chk("write_sig", {63'd0, write_sig}, {63'd0, v.exp_sig});
    chk("misalign_err", {63'd0, misalign_err}, {63'd0, v.exp_err});
    chk("wb_count", wb_count, exp_cnt);
    if (v.exp_sig) begin
      chk("write_reg", {59'd0, write_reg}, {59'd0, v.rd});
      chk("write_val", write_val, v.exp_val);
    end
    tick();
    chk("write_sig_after", {63'd0, write_sig}, 64'd0);
    chk("misalign_after", {63'd0, misalign_err}, 64'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cur_idx = -1;
    exp_cnt = '0;
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_write_sig", {63'd0, write_sig}, 64'd0);
    chk("rst_write_reg", {59'd0, write_reg}, 64'd0);
    chk("rst_write_val", write_val, 64'd0);
    chk("rst_misalign", {63'd0, misalign_err}, 64'd0);
    chk("rst_wb_count", wb_count, 64'd0);
    chk("rst_ld_ready", {63'd0, ld_ready}, 64'd1);
    chk("rst_alu_ready", {63'd0, alu_ready}, 64'd1);

    //           ld    rd     data                    off   sz     uns   sig   err   exp_val                 inc
    vecs[0]  = mk(1'b0, 5'd5,  64'h0000_0000_0000_1234, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 64'h0000_0000_0000_1234, 1'b1);
    vecs[1]  = mk(1'b1, 5'd7,  64'h0000_0000_0080_0000, 3'd2, 2'd0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 1'b1);
    vecs[2]  = mk(1'b1, 5'd7,  64'h0000_0000_0080_0000, 3'd2, 2'd0, 1'b1, 1'b1, 1'b0, 64'h0000_0000_0000_0080, 1'b1);
    vecs[3]  = mk(1'b1, 5'd9,  64'h8765_4321_0000_0000, 3'd4, 2'd2, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_8765_4321, 1'b1);
    vecs[4]  = mk(1'b1, 5'd9,  64'h8765_4321_0000_0000, 3'd4, 2'd2, 1'b1, 1'b1, 1'b0, 64'h0000_0000_8765_4321, 1'b1);
    vecs[5]  = mk(1'b1, 5'd3,  64'hBEEF_0000_0000_0000, 3'd6, 2'd1, 1'b1, 1'b1, 1'b0, 64'h0000_0000_0000_BEEF, 1'b1);
    vecs[6]  = mk(1'b1, 5'd3,  64'hBEEF_0000_0000_0000, 3'd6, 2'd1, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_BEEF, 1'b1);
    vecs[7]  = mk(1'b1, 5'd31, 64'h8000_0000_0000_0001, 3'd0, 2'd3, 1'b1, 1'b1, 1'b0, 64'h8000_0000_0000_0001, 1'b1);
    vecs[8]  = mk(1'b1, 5'd4,  64'h7F00_0000_0000_0000, 3'd7, 2'd0, 1'b0, 1'b1, 1'b0, 64'h0000_0000_0000_007F, 1'b1);
    vecs[9]  = mk(1'b1, 5'd8,  64'h0000_0000_8001_0000, 3'd2, 2'd1, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_8001, 1'b1);
    vecs[10] = mk(1'b1, 5'd6,  64'h1111_2222_3333_4444, 3'd2, 2'd2, 1'b0, 1'b0, 1'b1, 64'h0,                   1'b0);
    vecs[11] = mk(1'b1, 5'd6,  64'h1111_2222_3333_4444, 3'd1, 2'd1, 1'b0, 1'b0, 1'b1, 64'h0,                   1'b0);
    vecs[12] = mk(1'b1, 5'd6,  64'h1111_2222_3333_4444, 3'd4, 2'd3, 1'b0, 1'b0, 1'b1, 64'h0,                   1'b0);
    vecs[13] = mk(1'b0, 5'd0,  64'h0000_0000_0000_DEAD, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 64'h0,                   1'b1);
    vecs[14] = mk(1'b1, 5'd0,  64'h0000_0000_0000_00FF, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 64'h0,                   1'b1);
    vecs[15] = mk(1'b0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);

    for (int i = 0; i < 16; i++) begin
      cur_idx = i;
      run_vec(vecs[i]);
    end

    // Priority: two back-to-back loads beat a waiting ALU result
    cur_idx = 100;
    drive_ld(5'd10, 64'h0000_0000_0000_1111, 3'd0, 2'd3, 1'b0);
    tick();
    chk("pri_sig_e1", {63'd0, write_sig}, 64'd0);
    chk("pri_alu_ready_e1", {63'd0, alu_ready}, 64'd0);
    chk("pri_ld_ready_e1", {63'd0, ld_ready}, 64'd1);
    drive_ld(5'd11, 64'h0000_0000_0000_2222, 3'd0, 2'd3, 1'b0);
    alu_valid = 1'b1; alu_rd = 5'd12; alu_result = 64'h0000_0000_0000_AAAA;
    tick();
    exp_cnt = exp_cnt + 64'd1;
    chk("pri_sig_e2", {63'd0, write_sig}, 64'd1);
    chk("pri_reg_e2", {59'd0, write_reg}, 64'd10);
    chk("pri_val_e2", write_val, 64'h1111);
    chk("pri_alu_ready_e2", {63'd0, alu_ready}, 64'd0);
    ld_valid = 1'b0;
    tick();
    exp_cnt = exp_cnt + 64'd1;
    chk("pri_sig_e3", {63'd0, write_sig}, 64'd1);
    chk("pri_reg_e3", {59'd0, write_reg}, 64'd11);
    chk("pri_val_e3", write_val, 64'h2222);
    chk("pri_alu_ready_e3", {63'd0, alu_ready}, 64'd1);
    tick();
    alu_valid = 1'b0;
    exp_cnt = exp_cnt + 64'd1;
    chk("pri_sig_e4", {63'd0, write_sig}, 64'd1);
    chk("pri_reg_e4", {59'd0, write_reg}, 64'd12);
    chk("pri_val_e4", write_val, 64'hAAAA);
    chk("pri_count", wb_count, exp_cnt);
    tick();
    chk("pri_sig_e5", {63'd0, write_sig}, 64'd0);
    chk("pri_count_e5", wb_count, exp_cnt);

    // Reset mid-operation: load queued, another load and ALU in flight
    cur_idx = 200;
    drive_ld(5'd13, 64'h0000_0000_0000_3333, 3'd0, 2'd3, 1'b0);
    tick();
    drive_ld(5'd14, 64'h0000_0000_0000_4444, 3'd0, 2'd3, 1'b0);
    alu_valid = 1'b1; alu_rd = 5'd15; alu_result = 64'h5555;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    chk("mrst_write_sig", {63'd0, write_sig}, 64'd0);
    chk("mrst_write_reg", {59'd0, write_reg}, 64'd0);
    chk("mrst_write_val", write_val, 64'd0);
    chk("mrst_wb_count", wb_count, 64'd0);
    chk("mrst_ld_ready", {63'd0, ld_ready}, 64'd1);
    chk("mrst_alu_ready", {63'd0, alu_ready}, 64'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mrst_no_stale_sig", {63'd0, write_sig}, 64'd0);
      chk("mrst_no_stale_cnt", wb_count, 64'd0);
    end

    // Fresh ALU write after reset restarts the counter from zero
    cur_idx = 300;
    alu_valid = 1'b1; alu_rd = 5'd2; alu_result = 64'h0BAD_F00D;
    tick();
    alu_valid = 1'b0;
    chk("post_rst_sig", {63'd0, write_sig}, 64'd1);
    chk("post_rst_val", write_val, 64'h0BAD_F00D);
    chk("post_rst_cnt", wb_count, 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
